// File: rtl/fwd_hazard_if.sv
// ID-stage operand/destination info and the forwarding/stall controls for the
// LC-3b forwarding and hazard unit.
interface fwd_hazard_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic             mem_stall;
  logic             id_valid;
  logic [REG_W-1:0] id_sr1;
  logic             id_sr1_used;
  logic [REG_W-1:0] id_sr2;
  logic             id_sr2_used;
  logic [REG_W-1:0] id_st_src;
  logic             id_st_used;
  logic [REG_W-1:0] id_dest;
  logic             id_regwrite;
  logic             id_is_load;

  logic             a1_mux_sel;
  logic             a2_mux_sel;
  logic             b1_mux_sel;
  logic             b2_mux_sel;
  logic             c1_mux_sel;
  logic             c2_mux_sel;
  logic             stall_if_id;
  logic             bubble_id_ex;
  logic [CNT_W-1:0] fwd_count;
  logic [CNT_W-1:0] lu_stall_count;

  modport master (
    output mem_stall, id_valid, id_sr1, id_sr1_used, id_sr2, id_sr2_used,
           id_st_src, id_st_used, id_dest, id_regwrite, id_is_load,
    input  a1_mux_sel, a2_mux_sel, b1_mux_sel, b2_mux_sel, c1_mux_sel,
           c2_mux_sel, stall_if_id, bubble_id_ex, fwd_count, lu_stall_count
  );

  modport slave (
    input  mem_stall, id_valid, id_sr1, id_sr1_used, id_sr2, id_sr2_used,
           id_st_src, id_st_used, id_dest, id_regwrite, id_is_load,
    output a1_mux_sel, a2_mux_sel, b1_mux_sel, b2_mux_sel, c1_mux_sel,
           c2_mux_sel, stall_if_id, bubble_id_ex, fwd_count, lu_stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use hazard control for the 5-stage LC-3b pipeline.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fwd_hazard_unit #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  fwd_hazard_if.slave bus
);

  logic             ex_v, ex_rw, ex_ld;
  logic [REG_W-1:0] ex_dest;
  logic             mem_v, mem_rw;
  logic [REG_W-1:0] mem_dest;

  logic he_a, he_b, he_c, hm_a, hm_b, hm_c;
  logic load_use, advance, any_fwd;
  logic a1_q, a2_q, b1_q, b2_q, c1_q, c2_q;

  function automatic logic hit(input logic used, input logic v, input logic rw,
                               input logic [REG_W-1:0] dest,
                               input logic [REG_W-1:0] src);
    return used & v & rw & (dest == src);
  endfunction

  always_comb begin
    he_a     = hit(bus.id_sr1_used, ex_v, ex_rw, ex_dest, bus.id_sr1);
    he_b     = hit(bus.id_sr2_used, ex_v, ex_rw, ex_dest, bus.id_sr2);
    he_c     = hit(bus.id_st_used,  ex_v, ex_rw, ex_dest, bus.id_st_src);
    hm_a     = hit(bus.id_sr1_used, mem_v, mem_rw, mem_dest, bus.id_sr1);
    hm_b     = hit(bus.id_sr2_used, mem_v, mem_rw, mem_dest, bus.id_sr2);
    hm_c     = hit(bus.id_st_used,  mem_v, mem_rw, mem_dest, bus.id_st_src);
    // A load in EX cannot forward yet: its data only exists after MEM.
    load_use = bus.id_valid & ex_ld & (he_a | he_b | he_c);
    advance  = ~bus.mem_stall;
    any_fwd  = bus.id_valid & (he_a | hm_a | he_b | hm_b | he_c | hm_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_v     <= 1'b0;
      ex_rw    <= 1'b0;
      ex_ld    <= 1'b0;
      ex_dest  <= '0;
      mem_v    <= 1'b0;
      mem_rw   <= 1'b0;
      mem_dest <= '0;
      a1_q <= 1'b0; a2_q <= 1'b0;
      b1_q <= 1'b0; b2_q <= 1'b0;
      c1_q <= 1'b0; c2_q <= 1'b0;
    end else if (advance) begin
      mem_v    <= ex_v;
      mem_rw   <= ex_rw;
      mem_dest <= ex_dest;
      ex_dest  <= bus.id_dest;
      ex_rw    <= bus.id_regwrite;
      ex_ld    <= bus.id_is_load;
      if (load_use || !bus.id_valid) begin
        ex_v <= bus.id_valid & ~load_use;
        a1_q <= 1'b0; a2_q <= 1'b0;
        b1_q <= 1'b0; b2_q <= 1'b0;
        c1_q <= 1'b0; c2_q <= 1'b0;
      end else begin
        ex_v <= 1'b1;
        a1_q <= he_a | hm_a; a2_q <= he_a;
        b1_q <= he_b | hm_b; b2_q <= he_b;
        c1_q <= he_c | hm_c; c2_q <= he_c;
      end
    end
  end

  assign bus.a1_mux_sel   = a1_q;
  assign bus.a2_mux_sel   = a2_q;
  assign bus.b1_mux_sel   = b1_q;
  assign bus.b2_mux_sel   = b2_q;
  assign bus.c1_mux_sel   = c1_q;
  assign bus.c2_mux_sel   = c2_q;
  assign bus.stall_if_id  = load_use;
  assign bus.bubble_id_ex = load_use & advance;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_cnt, lu_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fwd_cnt <= '0;
      lu_cnt  <= '0;
    end else if (advance) begin
      if (!load_use && any_fwd && fwd_cnt != {CNT_W{1'b1}})
        fwd_cnt <= fwd_cnt + CNT_W'(1);
      if (load_use && lu_cnt != {CNT_W{1'b1}})
        lu_cnt <= lu_cnt + CNT_W'(1);
    end
  end

  assign bus.fwd_count      = fwd_cnt;
  assign bus.lu_stall_count = lu_cnt;
`else
  logic unused_stats;
  assign unused_stats       = any_fwd;
  assign bus.fwd_count      = {CNT_W{1'b0}};
  assign bus.lu_stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed self-checking bench for fwd_hazard_unit: forwarding selects,
// load-use stall/bubble, mem_stall freeze and asynchronous reset.
module tb_fwd_hazard_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   passed = 0;
  int   total = 0;

  always #5 clk = ~clk;

  fwd_hazard_if bus ();

  fwd_hazard_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Select bundle ordered {a1,a2,b1,b2,c1,c2}.
  function automatic logic [5:0] sels();
    return {bus.a1_mux_sel, bus.a2_mux_sel, bus.b1_mux_sel,
            bus.b2_mux_sel, bus.c1_mux_sel, bus.c2_mux_sel};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v,
                       input logic [2:0] s1, input logic u1,
                       input logic [2:0] s2, input logic u2,
                       input logic [2:0] st, input logic ust,
                       input logic [2:0] dest, input logic rw, input logic ld);
    bus.id_valid    = v;
    bus.id_sr1      = s1;
    bus.id_sr1_used = u1;
    bus.id_sr2      = s2;
    bus.id_sr2_used = u2;
    bus.id_st_src   = st;
    bus.id_st_used  = ust;
    bus.id_dest     = dest;
    bus.id_regwrite = rw;
    bus.id_is_load  = ld;
  endtask

  task automatic nop();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bus.mem_stall = 1'b0;
    nop();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (sels() !== 6'b000000) $display("[TB] FAIL reset_sels got %b want 000000", sels());
    else passed++;
    total++;
    if ({bus.stall_if_id, bus.bubble_id_ex} !== 2'b00)
      $display("[TB] FAIL reset_stall got %b want 00", {bus.stall_if_id, bus.bubble_id_ex});
    else passed++;
    total++;
    if (bus.fwd_count !== 16'd0 || bus.lu_stall_count !== 16'd0)
      $display("[TB] FAIL reset_counts got %0d/%0d want 0/0", bus.fwd_count, bus.lu_stall_count);
    else passed++;
  endtask

  task automatic test_ex_forward();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    tick();
    total++;
    if (sels() !== 6'b110000) $display("[TB] FAIL ex_forward got %b want 110000", sels());
    else passed++;
  endtask

  task automatic test_mem_forward();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    drive(1'b1, 3'd5, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    tick();
    total++;
    if (sels() !== 6'b001000) $display("[TB] FAIL mem_forward got %b want 001000", sels());
    else passed++;
  endtask

  task automatic test_newer_wins();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd2, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    tick();
    total++;
    if (sels() !== 6'b111100) $display("[TB] FAIL newer_wins got %b want 111100", sels());
    else passed++;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
    #1;
    total++;
    if ({bus.stall_if_id, bus.bubble_id_ex} !== 2'b11)
      $display("[TB] FAIL lu_stall got %b want 11", {bus.stall_if_id, bus.bubble_id_ex});
    else passed++;
    tick();
    total++;
    if (sels() !== 6'b000000) $display("[TB] FAIL lu_bubble_sels got %b want 000000", sels());
    else passed++;
    total++;
    if ({bus.stall_if_id, bus.bubble_id_ex} !== 2'b00)
      $display("[TB] FAIL lu_one_cycle got %b want 00", {bus.stall_if_id, bus.bubble_id_ex});
    else passed++;
    tick();
    total++;
    if (sels() !== 6'b101000) $display("[TB] FAIL lu_retry got %b want 101000", sels());
    else passed++;
`ifdef FWD_STATS_EN
    total++;
    if (bus.lu_stall_count !== 16'd1 || bus.fwd_count !== 16'd1)
      $display("[TB] FAIL lu_counts got %0d/%0d want 1/1", bus.lu_stall_count, bus.fwd_count);
    else passed++;
`else
    total++;
    if (bus.lu_stall_count !== 16'd0 || bus.fwd_count !== 16'd0)
      $display("[TB] FAIL lu_counts got %0d/%0d want 0/0", bus.lu_stall_count, bus.fwd_count);
    else passed++;
`endif
  endtask

  task automatic test_load_use_frozen();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    drive(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0);
    bus.mem_stall = 1'b1;
    tick();
    total++;
    if ({bus.stall_if_id, bus.bubble_id_ex} !== 2'b10)
      $display("[TB] FAIL frozen_lu got %b want 10", {bus.stall_if_id, bus.bubble_id_ex});
    else passed++;
    bus.mem_stall = 1'b0;
    #1;
    total++;
    if ({bus.stall_if_id, bus.bubble_id_ex} !== 2'b11)
      $display("[TB] FAIL frozen_release got %b want 11", {bus.stall_if_id, bus.bubble_id_ex});
    else passed++;
  endtask

  task automatic test_mem_stall();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd1, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (sels() !== 6'b000000 || bus.bubble_id_ex !== 1'b0)
        $display("[TB] FAIL stall_hold cycle %0d got %b/%b want 000000/0", i, sels(), bus.bubble_id_ex);
      else passed++;
    end
    bus.mem_stall = 1'b0;
    tick();
    total++;
    if (sels() !== 6'b110000) $display("[TB] FAIL stall_release got %b want 110000", sels());
    else passed++;
  endtask

  task automatic test_store_forward();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0);
    tick();
    total++;
    if (sels() !== 6'b000011) $display("[TB] FAIL store_forward got %b want 000011", sels());
    else passed++;
  endtask

  task automatic test_invalid_id();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 3'd1, 1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0);
    #1;
    total++;
    if (bus.stall_if_id !== 1'b0) $display("[TB] FAIL invalid_stall got %b want 0", bus.stall_if_id);
    else passed++;
    tick();
    total++;
    if (sels() !== 6'b000000) $display("[TB] FAIL invalid_sels got %b want 000000", sels());
    else passed++;
  endtask

  task automatic test_r0();
    do_reset();
    drive(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd0, 1'b1, 3'd5, 1'b1, 3'd0, 1'b1, 3'd4, 1'b1, 1'b0);
    tick();
    total++;
    if (sels() !== 6'b110011) $display("[TB] FAIL r0_forward got %b want 110011", sels());
    else passed++;
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    drive(1'b1, 3'd3, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
    tick();
    drive(1'b1, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b1);
    tick();
    total++;
    if (sels() !== 6'b110000) $display("[TB] FAIL pre_reset_sels got %b want 110000", sels());
    else passed++;
    drive(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
    #1;
    total++;
    if (bus.stall_if_id !== 1'b1) $display("[TB] FAIL pre_reset_stall got %b want 1", bus.stall_if_id);
    else passed++;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.stall_if_id, bus.bubble_id_ex} !== 2'b00 || sels() !== 6'b000000)
      $display("[TB] FAIL async_reset got %b/%b want 00/000000",
               {bus.stall_if_id, bus.bubble_id_ex}, sels());
    else passed++;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bus.mem_stall = 1'b0;
    nop();
    test_reset();
    test_ex_forward();
    test_mem_forward();
    test_newer_wins();
    test_load_use();
    test_load_use_frozen();
    test_mem_stall();
    test_store_forward();
    test_invalid_id();
    test_r0();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Forwarding and hazard control for the 5-stage LC-3b pipeline. It drives the a1/a2/b1/b2/c1/c2 forwarding-mux selects that the EX stage consumes, and generates the load-use stall and bubble. It tracks the destination register of every in-flight instruction in internal shadow slots (EX, MEM). Selects are registered on the ID->EX advance, so they are stable for the whole EX cycle.

Parameters:
REG_W, 3, register index width
CNT_W, 16, width of statistics counters (used only with FWD_STATS_EN)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
mem_stall  in  1  global pipeline freeze (cache miss in progress)
id_valid  in  1  ID stage holds a real instruction
id_sr1  in  REG_W  ALU operand A source register
id_sr1_used  in  1  operand A is read from the register file
id_sr2  in  REG_W  ALU operand B source register
id_sr2_used  in  1  operand B is read (0 for immediate forms)
id_st_src  in  REG_W  store-data source register (STR/STB/STI)
id_st_used  in  1  instruction is a store
id_dest  in  REG_W  destination register
id_regwrite  in  1  instruction writes id_dest
id_is_load  in  1  result is produced in MEM (LDR/LDB/LDI/LEA excluded)
a1_mux_sel, b1_mux_sel, c1_mux_sel  out  1 each  1 = take forwarded value
a2_mux_sel, b2_mux_sel, c2_mux_sel  out  1 each  1 = ex_mem_alu, 0 = mem_wb_reg
stall_if_id  out  1  hold PC and IF/ID
bubble_id_ex  out  1  load NOP control into ID/EX
fwd_count  out  CNT_W  forward events (FWD_STATS_EN only)
lu_stall_count  out  CNT_W  load-use stall cycles (FWD_STATS_EN only)

Behaviour:
- Clock is clk. Reset is reset: asynchronous and active-high.
- Shadow slots EX and MEM each hold {v, dest, rw, ld}. Reset clears v=0 in both slots, drives all six selects to 0, and clears both counters to 0.
- load_use (combinational) = id_valid & EX.v & EX.rw & EX.ld & any used source (sr1, sr2, st_src) equal to EX.dest.
- stall_if_id = load_use. bubble_id_ex = load_use & ~mem_stall.
- mem_stall=1: slots, selects and counters all hold.
- Advance edge (~mem_stall):
  - MEM <= EX.
  - If load_use: EX <= invalid, and all selects <= 0.
  - Otherwise: EX <= {id_valid, id_dest, id_regwrite, id_is_load}, and selects are computed per source path s (a: sr1, b: sr2, c: st_src).
- Select computation for path s with used flag u:
  - hE = u & EX.v & EX.rw & (EX.dest==s)
  - hM = u & MEM.v & MEM.rw & (MEM.dest==s)
  - x1 <= hE | hM
  - x2 <= hE (the newer producer wins when both match)
  - If id_valid=0, all selects <= 0.
- Load-use produces exactly one bubble cycle. After the bubble the load sits in MEM, so the retry forwards from mem_wb_reg with x1=1, x2=0.
- The register file writes through in the WB cycle. ID-vs-WB dependences need no action from this block.
- R0 gets no special treatment; every register can be a forwarding target.
- Reset asserted mid-stall: stall outputs drop immediately (slots become invalid).

Optional Feature:
FWD_STATS_EN
- Defined:
  - fwd_count increments by 1 on each advance edge that sets any x1.
  - lu_stall_count increments on each cycle with bubble_id_ex=1.
  - Both counters saturate at all-ones.
- Undefined: counters are not instantiated, and both ports are tied to 0.

Test Plan:
1. ADD R1<-R2,R3 then ADD R4<-R1,R5 back-to-back -> in the consumer's EX cycle a1=1, a2=1, b1=0.
2. ADD R1, NOP, ADD R4<-R5,R1 -> b1=1, b2=0, a1=0.
3. ADD R1 (R1=3), ADD R1 (R1=7), ADD R6<-R1,R1 -> a1=b1=1, a2=b2=1 (value 7 path).
4. LDR R4 then ADD R5<-R4,R4 -> stall_if_id=1 and bubble_id_ex=1 for exactly 1 cycle; EX sees a bubble with all selects 0; the next cycle has a1=b1=1, a2=b2=0. With FWD_STATS_EN, lu_stall_count=1.
5. Case 1 with mem_stall=1 held 3 cycles just before the advance -> selects and slots unchanged for 3 cycles, no bubble; after release, the same result as case 1.
6. ADD R6 then STR R6,R2,#0 -> c1=1, c2=1, a1=0. Assert reset during a load-use stall -> stall_if_id=0 asynchronously and all selects 0.
